// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: one iterative shifter shared round-robin by two requesters
// (port 0 branch/target path, port 1 ALU shift path). It accepts one op from
// IDLE, shifts by up to STEP bits per SHIFT cycle, and strobes the result in DONE.
// Latency: the ack cycle is cycle 0; valid_o rises in cycle ceil(shamt/STEP)+1.
// Backpressure: requesters hold req until ack. Nothing is accepted while busy_o=1.
// Build option: define SHIFT_ARITH_EN to make op 10 an arithmetic right shift.
//   Without it, op 10 is a logical right shift.
// Ports:
//   clk_i, rst_i       clock (rising edge); synchronous active-low reset
//   reqN_i             request from port N, held until ackN_o
//   dataN_i            operand, WIDTH bits
//   shamtN_i           shift amount, SHW bits
//   opN_i              00 SLL, 01 SRL, 10 SRA, 11 treated as SLL
//   ackN_o             one-cycle accept pulse
//   busy_o             engine is not IDLE
//   valid_o            one-cycle result strobe
//   result_o, id_o     last result and the port that owns it
module shift_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int SHW   = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [SHW-1:0]   shamt0_i,
  input  logic [1:0]       op0_i,
  output logic             ack0_o,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [SHW-1:0]   shamt1_i,
  input  logic [1:0]       op1_i,
  output logic             ack1_o,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             id_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic [WIDTH-1:0] work, work_step;
  logic [SHW-1:0]   remaining, step_n;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH-1:0] result_q;
  logic             id_hold_q;
  logic             gnt0, gnt1;

  // Round robin: on a tie, the port that did not win last time gets the grant.
  // After reset last_grant=1, so port 0 wins the first tie.
  always_comb begin
    gnt0 = (state == IDLE) && req0_i && (!req1_i || last_grant);
    gnt1 = (state == IDLE) && req1_i && (!req0_i || !last_grant);
  end

  assign ack0_o = gnt0;
  assign ack1_o = gnt1;

  // Shift distance for this cycle: min(STEP, remaining).
  assign step_n = (remaining > SHW'(STEP)) ? SHW'(STEP) : remaining;

  always_comb begin
    work_step = work << step_n;
    case (op_q)
      2'b01: work_step = work >> step_n;
`ifdef SHIFT_ARITH_EN
      2'b10: work_step = $unsigned($signed(work) >>> step_n);
`else
      2'b10: work_step = work >> step_n;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt0)
          state_nxt = (shamt0_i == '0) ? DONE : SHIFT;
        else if (gnt1)
          state_nxt = (shamt1_i == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (remaining == step_n)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      work       <= '0;
      remaining  <= '0;
      op_q       <= 2'b00;
      id_q       <= 1'b0;
      result_q   <= '0;
      id_hold_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt0) begin
            work       <= data0_i;
            remaining  <= shamt0_i;
            op_q       <= op0_i;
            id_q       <= 1'b0;
            last_grant <= 1'b0;
          end else if (gnt1) begin
            work       <= data1_i;
            remaining  <= shamt1_i;
            op_q       <= op1_i;
            id_q       <= 1'b1;
            last_grant <= 1'b1;
          end
        end
        SHIFT: begin
          work      <= work_step;
          remaining <= remaining - step_n;
        end
        DONE: begin
          // Keep the delivered result visible until the next DONE.
          result_q  <= work;
          id_hold_q <= id_q;
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = (state != IDLE);
  assign valid_o  = (state == DONE);
  // During DONE the fresh result comes straight from the working register.
  assign result_o = valid_o ? work : result_q;
  assign id_o     = valid_o ? id_q : id_hold_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Bench for shift_unit_arbiter: directed scenarios with literal expectations,
// then random traffic. Every output is compared each cycle against a
// transaction-level model.
module tb_shift_unit_arbiter;
  localparam int STEP = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic [4:0]  shamt0 = '0, shamt1 = '0;
  logic [1:0]  op0 = '0, op1 = '0;
  logic        ack0_o, ack1_o, busy_o, valid_o, id_o;
  logic [31:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit rand_on = 1'b0;

  shift_unit_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .req0_i(req0), .data0_i(data0), .shamt0_i(shamt0), .op0_i(op0), .ack0_o(ack0_o),
    .req1_i(req1), .data1_i(data1), .shamt1_i(shamt1), .op1_i(op1), .ack1_o(ack1_o),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .id_o(id_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int sh, input logic [1:0] op);
    case (op)
      2'b01: return d >> sh;
`ifdef SHIFT_ARITH_EN
      2'b10: return $unsigned($signed(d) >>> sh);
`else
      2'b10: return d >> sh;
`endif
      default: return d << sh;
    endcase
  endfunction

  // Transaction-level model. An accepted op occupies the engine until
  // accept_cycle + ceil(shamt/STEP) + 1, when its result is delivered.
  bit          m_idle = 1'b1;
  bit          m_last = 1'b1;
  int          m_done = 0;
  logic [31:0] m_res = '0, m_hres = '0;
  logic        m_id = 1'b0, m_hid = 1'b0;
  logic        e_a0, e_a1, e_v, e_id;
  logic [31:0] e_r;
  int          sh;

  always @(negedge clk) begin
    if (!rst_i) begin
      m_idle = 1'b1; m_last = 1'b1; m_hres = '0; m_hid = 1'b0;
    end else begin
      e_a0 = m_idle && req0 && (!req1 || m_last);
      e_a1 = m_idle && req1 && (!req0 || !m_last);
      e_v  = !m_idle && (cyc == m_done);
      e_r  = e_v ? m_res : m_hres;
      e_id = e_v ? m_id : m_hid;
      chk("ack0",   32'(ack0_o),  32'(e_a0));
      chk("ack1",   32'(ack1_o),  32'(e_a1));
      chk("busy",   32'(busy_o),  32'(!m_idle));
      chk("valid",  32'(valid_o), 32'(e_v));
      chk("result", result_o,     e_r);
      chk("id",     32'(id_o),    32'(e_id));
      if (e_v) begin
        m_idle = 1'b1; m_hres = m_res; m_hid = m_id;
      end else if (e_a0 || e_a1) begin
        sh     = e_a1 ? int'(shamt1) : int'(shamt0);
        m_res  = e_a1 ? ref_shift(data1, sh, op1) : ref_shift(data0, sh, op0);
        m_idle = 1'b0;
        m_done = cyc + (sh + STEP - 1) / STEP + 1;
        m_id   = e_a1;
        m_last = e_a1;
      end
    end
  end

  // Random requesters: they hold operands until acked, occasionally withdraw
  // a request, and occasionally pulse reset.
  logic s0, s1;
  initial begin
    forever begin
      @(negedge clk);
      s0 = ack0_o; s1 = ack1_o;
      @(posedge clk);
      #1;
      if (rand_on) begin
        rst_i = ($urandom % 200) != 0;
        if (req0 && s0) begin
          if ($urandom % 2 == 0) req0 = 1'b0;
          else begin data0 = $urandom; shamt0 = 5'($urandom_range(0, 31)); op0 = 2'($urandom); end
        end else if (req0) begin
          if ($urandom % 16 == 0) req0 = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req0 = 1'b1; data0 = $urandom; shamt0 = 5'($urandom_range(0, 31)); op0 = 2'($urandom);
        end
        if (req1 && s1) begin
          if ($urandom % 2 == 0) req1 = 1'b0;
          else begin data1 = $urandom; shamt1 = 5'($urandom_range(0, 31)); op1 = 2'($urandom); end
        end else if (req1) begin
          if ($urandom % 16 == 0) req1 = 1'b0;
        end else if ($urandom % 3 == 0) begin
          req1 = 1'b1; data1 = $urandom; shamt1 = 5'($urandom_range(0, 31)); op1 = 2'($urandom);
        end
      end
    end
  end

  // Issue one op on a port, then check latency (ack cycle = 0), result and id.
  task automatic run_op(input bit port, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input int exp_lat, input logic [31:0] exp_res);
    int  t0;
    bit  got;
    @(posedge clk); #1;
    if (port) begin req1 = 1'b1; data1 = d; shamt1 = s; op1 = op; end
    else      begin req0 = 1'b1; data0 = d; shamt0 = s; op0 = op; end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (port ? ack1_o : ack0_o) got = 1'b1;
    end
    if (!got) begin timeout("ack_wait"); return; end
    t0 = cyc;
    @(posedge clk); #1;
    // Operands changing after ack must not disturb the op in flight.
    if (port) begin req1 = 1'b0; data1 = $urandom; shamt1 = 5'($urandom); op1 = 2'($urandom); end
    else      begin req0 = 1'b0; data0 = $urandom; shamt0 = 5'($urandom); op0 = 2'($urandom); end
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (valid_o) got = 1'b1;
    end
    if (!got) begin timeout("valid_wait"); return; end
    chk("op_latency", 32'(cyc - t0), 32'(exp_lat));
    chk("op_result",  result_o, exp_res);
    chk("op_id",      32'(id_o), 32'(port));
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (!busy_o) done = 1'b1;
    end
    if (!done) timeout("idle_wait");
  endtask

  int order[3];
  int n_ack;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk("rst_busy",   32'(busy_o),  32'd0);
    chk("rst_valid",  32'(valid_o), 32'd0);
    chk("rst_result", result_o,     32'd0);
    chk("rst_id",     32'(id_o),    32'd0);

    run_op(1'b0, 32'h0000_0001, 5'd2,  2'b00, 2,  32'h0000_0004);
    run_op(1'b1, 32'h0000_0001, 5'd31, 2'b00, 17, 32'h8000_0000);
    run_op(1'b0, 32'hDEAD_BEEF, 5'd0,  2'b01, 1,  32'hDEAD_BEEF);
`ifdef SHIFT_ARITH_EN
    run_op(1'b1, 32'h8000_0000, 5'd4,  2'b10, 3,  32'hF800_0000);
`else
    run_op(1'b1, 32'h8000_0000, 5'd4,  2'b10, 3,  32'h0800_0000);
`endif
    run_op(1'b0, 32'h0000_00F0, 5'd3,  2'b11, 3,  32'h0000_0780);

    // Both ports requesting from reset release: expect grants 0, 1, 0.
    @(posedge clk); #1;
    rst_i = 1'b0;
    req0 = 1'b1; data0 = 32'h0000_0003; shamt0 = 5'd3; op0 = 2'b00;
    req1 = 1'b1; data1 = 32'h0000_0100; shamt1 = 5'd1; op1 = 2'b01;
    @(posedge clk); #1 rst_i = 1'b1;
    n_ack = 0;
    for (int i = 0; i < 100 && n_ack < 3; i++) begin
      @(negedge clk);
      if (ack0_o && ack1_o) chk("ack_overlap", 32'd1, 32'd0);
      if (ack0_o) begin order[n_ack] = 0; n_ack++; end
      else if (ack1_o) begin order[n_ack] = 1; n_ack++; end
    end
    @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
    if (n_ack < 3) timeout("tie_acks");
    else begin
      chk("tie_first",  32'(order[0]), 32'd0);
      chk("tie_second", 32'(order[1]), 32'd1);
      chk("tie_third",  32'(order[2]), 32'd0);
    end
    wait_idle();

    // Reset in the middle of a long shift aborts it.
    @(posedge clk); #1;
    req0 = 1'b1; data0 = 32'h0000_0005; shamt0 = 5'd20; op0 = 2'b00;
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack == 0; i++) begin
      @(negedge clk);
      if (ack0_o) n_ack = 1;
    end
    if (n_ack == 0) timeout("abort_ack");
    @(posedge clk); #1 req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    req1 = 1'b1; data1 = 32'h1234_5678; shamt1 = 5'd1; op1 = 2'b00;
    @(negedge clk);
    chk("abort_busy",   32'(busy_o),  32'd0);
    chk("abort_valid",  32'(valid_o), 32'd0);
    chk("abort_result", result_o,     32'd0);
    chk("abort_id",     32'(id_o),    32'd0);
    chk("abort_ack1",   32'(ack1_o),  32'd1);
    @(posedge clk); #1 req1 = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 20 && n_ack == 0; i++) begin
      @(negedge clk);
      if (valid_o) n_ack = 1;
    end
    if (n_ack == 0) timeout("abort_valid_wait");
    else begin
      chk("after_abort_result", result_o, 32'h2468_ACF0);
      chk("after_abort_id",     32'(id_o), 32'd1);
    end
    wait_idle();

    rand_on = 1'b1;
    repeat (4000) @(posedge clk);
    @(negedge clk) rand_on = 1'b0;
    @(posedge clk); #2;
    rst_i = 1'b1; req0 = 1'b0; req1 = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares one iterative shift engine between two requesters: port 0 (branch/target path) and port 1 (ALU shift path).
- Arbitrates round-robin and captures operands on accept.
- Shifts by at most STEP bits per cycle, then presents the result for one cycle with the winner's ID.
- Replaces per-client fixed shifters, e.g. the constant left-by-two on the branch offset, with one sequenced resource.

Parameters:
- WIDTH, 32, data width.
- STEP, 2, maximum shift distance per SHIFT cycle. Legal values: 1, 2, 4.
- SHW, 5, shift-amount width. Must equal log2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- req0_i  in  1  requester 0 request, held until ack0_o.
- data0_i  in  WIDTH  requester 0 operand.
- shamt0_i  in  SHW  requester 0 shift amount.
- op0_i  in  2  requester 0 op: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- ack0_o  out  1  one-cycle accept pulse to requester 0.
- req1_i, data1_i, shamt1_i, op1_i, ack1_o: same as the port 0 set, for requester 1.
- busy_o  out  1  engine not IDLE.
- valid_o  out  1  one-cycle result strobe.
- result_o  out  WIDTH  shifted value; held until the next DONE.
- id_o  out  1  requester owning result_o.

Behaviour:
- Reset (rst_i=0 at a rising edge) applies regardless of state:
  - state=IDLE; busy_o=0, valid_o=0, ack0_o=0, ack1_o=0, result_o=0, id_o=0.
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the port != last_grant.
  - On a grant: pulse the matching ack for this cycle (combinational from state+req), capture data/shamt/op/id at the edge, and set last_grant=id.
  - Next state: DONE if shamt==0, else SHIFT.
- SHIFT:
  - Each cycle, shift the working register by n=min(STEP, remaining) and set remaining-=n.
  - Go to DONE when remaining reaches 0.
  - Cycle count k=ceil(shamt/STEP).
- DONE: valid_o=1 and result_o/id_o are updated for exactly this cycle; next state IDLE. No request is accepted in DONE.
- Latency: with the ack cycle as cycle 0, valid_o asserts in cycle k+1; shamt=0 gives valid in cycle 1.
- Throughput: one op per k+2 cycles.
- Shift semantics: SLL and SRL zero-fill; op 11 behaves as SLL.
- Width rules: shamt is unsigned, 0..WIDTH-1, with no overflow path. Bits shifted out are discarded.
- Requesters:
  - Operands must stay stable only while req is high and ack is low; changes after ack are ignored.
  - A req dropped before ack is legal and produces no ack.
- busy_o=1 in SHIFT and DONE.
- Reset mid-SHIFT or mid-DONE aborts the op: no valid_o, and the requester is not re-acked unless it re-requests.

Optional Feature:
- Macro SHIFT_ARITH_EN.
  - Defined: op 10 is an arithmetic right shift; each step sign-fills with bit WIDTH-1 of the working register.
  - Undefined: op 10 decodes as SRL (zero-fill); no sign logic is synthesized.

Test Plan:
1. After reset, port 0 sends data0=0x0000_0001, shamt=2, SLL (STEP=2) -> ack0_o in cycle 0; valid_o in cycle 2 with result_o=0x0000_0004, id_o=0.
2. Port 1 sends data1=0x0000_0001, shamt=31, SLL -> 16 SHIFT cycles; valid_o in cycle 17 with result_o=0x8000_0000, id_o=1; busy_o=1 during cycles 1..17.
3. req0 and req1 both held from reset release -> port 0 acked first, then port 1 acked in the IDLE cycle after DONE; a third tie goes to port 0; acks never overlap.
4. shamt=0, data=0xDEAD_BEEF, SRL -> valid_o in cycle 1, result_o=0xDEAD_BEEF.
5. data=0x8000_0000, shamt=4, op=10 -> result 0xF800_0000 with SHIFT_ARITH_EN defined, 0x0800_0000 without it.
6. rst_i=0 for one cycle during SHIFT of a shamt=20 op -> valid_o stays 0, outputs return to reset values, and a new request is acked in the first IDLE cycle after reset.
